// File: rtl/wb_slave_ram.sv
// Wishbone classic slave backed by a word RAM.
// Adds programmable wait states; flags misaligned or out-of-range accesses with err.
module wb_slave_ram #(
  parameter int          ADDR_WIDTH  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] wbs_addr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] WS_LOAD =
    (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] dat_q;
  logic [3:0]  sel_q;
  logic        we_q;

  logic [31:0] ram [0:DEPTH-1];

  logic                  req;
  logic [31:0]           cur_addr;
  logic [31:0]           cur_dat;
  logic [3:0]            cur_sel;
  logic                  cur_we;
  logic [31:0]           off;
  logic                  valid;
  logic [ADDR_WIDTH-1:0] idx;
  logic                  enter;

  // In IDLE the live bus is decoded so zero-wait-state responses are possible.
  always_comb begin
    req      = wbs_cyc_i & wbs_stb_i;
    cur_addr = (state == S_IDLE) ? wbs_addr_i : addr_q;
    cur_dat  = (state == S_IDLE) ? wbs_dat_i  : dat_q;
    cur_sel  = (state == S_IDLE) ? wbs_sel_i  : sel_q;
    cur_we   = (state == S_IDLE) ? wbs_we_i   : we_q;
    off      = cur_addr - BASE_ADDR;
    valid    = ({1'b0, off} < (33'd4 << ADDR_WIDTH))
               && (cur_addr[1:0] == 2'b00);
    idx      = off[ADDR_WIDTH+1:2];
    enter    = 1'b0;
    if (state == S_IDLE && req && WAIT_STATES == 0)
      enter = 1'b1;
    if (state == S_WAIT && req && cnt == 4'd0)
      enter = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      wbs_dat_o <= 32'h0;
    end else begin
      wbs_ack_o <= 1'b0;
      wbs_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            addr_q <= wbs_addr_i;
            dat_q  <= wbs_dat_i;
            sel_q  <= wbs_sel_i;
            we_q   <= wbs_we_i;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WS_LOAD;
            end
          end
        end
        S_WAIT: begin
          if (!req)
            state <= S_IDLE;
          else if (cnt == 4'd0)
            state <= S_RESP;
          else
            cnt <= cnt - 4'd1;
        end
        S_RESP:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (enter) begin
        wbs_ack_o <= valid;
        wbs_err_o <= ~valid;
        if (valid && !cur_we)
          wbs_dat_o <= ram[idx];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && enter && valid && cur_we) begin
      for (int i = 0; i < 4; i++)
        if (cur_sel[i])
          ram[idx][8*i +: 8] <= cur_dat[8*i +: 8];
    end
  end

endmodule
